// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC request scheduler and its arbiter.
package mac_pkg;

  localparam int unsigned MAC_W       = 256;
  localparam int unsigned MAC_NREQ    = 4;
  localparam int unsigned MAC_TIMEOUT = 200;
  localparam int unsigned MAC_PW      = 2 * MAC_W;
  localparam int unsigned MAC_WDOG_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_RESP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping mod NREQ.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id,
  output logic            o_any
);

  // Smallest rotational distance from the pointer wins.
  always_comb begin
    int unsigned     v_dist;
    int unsigned     v_best;
    logic [NREQ-1:0] v_sh;
    o_id   = '0;
    o_any  = 1'b0;
    v_best = NREQ;
    v_dist = 0;
    v_sh   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      v_sh   = i_req >> j;
      v_dist = (j >= 32'(i_ptr)) ? (j - 32'(i_ptr)) : (j + NREQ - 32'(i_ptr));
      if (v_sh[0] && (v_dist < v_best)) begin
        v_best = v_dist;
        o_id   = IDW'(j);
        o_any  = 1'b1;
      end
    end
    o_grant = o_any ? (NREQ'(1) << o_id) : '0;
  end

endmodule

// File: rtl/mac_req_sched.sv
// Round-robin scheduler sharing one multi-cycle MAC multiplier among NREQ clients; owns the accumulator bank.
// Optional BUSY watchdog that aborts a stuck engine op: define MAC_SCHED_TIMEOUT_EN.
module mac_req_sched
  import mac_pkg::*;
#(
  parameter  int unsigned W       = MAC_W,
  parameter  int unsigned NREQ    = MAC_NREQ,
`ifdef MAC_SCHED_TIMEOUT_EN
  parameter  int unsigned TIMEOUT = MAC_TIMEOUT,
`endif
  localparam int unsigned IDW     = $clog2(NREQ),
  localparam int unsigned PW      = 2 * W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_acc,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [PW-1:0]     mul_p,
  output logic              mul_abort,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [PW-1:0]     resp_data,
  output logic              resp_err
);

  sched_state_e    r_state, w_state_nxt;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic            w_any;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic            r_flag;
  logic            r_mul_start;
  logic [W-1:0]    r_mul_a;
  logic [W-1:0]    r_mul_b;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic [PW-1:0]   r_resp_data;
  logic [PW-1:0]   r_acc [NREQ];
  logic [PW-1:0]   w_acc_cur;
  logic [PW-1:0]   w_acc_new;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_accept;
  logic            w_abort;
  logic            w_done;
  logic            w_hs;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_id    (w_gid),
    .o_any   (w_any)
  );

  assign w_accept  = (r_state == S_IDLE) && w_any;
  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;
  assign w_done    = (r_state == S_BUSY) && mul_done && !w_abort;
  assign w_hs      = (r_state == S_RESP) && resp_ready;
  assign w_acc_cur = r_acc[r_id];
  assign w_acc_new = (r_flag ? w_acc_cur : '0) + mul_p;
  assign w_ptr_nxt = (32'(r_id) == (NREQ - 1)) ? '0 : (r_id + IDW'(1));

`ifdef MAC_SCHED_TIMEOUT_EN
  logic [MAC_WDOG_W-1:0] r_wdog;
  logic                  r_mul_abort;

  // Abort is raised in BUSY cycle TIMEOUT, so it is armed one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog      <= '0;
      r_mul_abort <= 1'b0;
    end else begin
      r_mul_abort <= 1'b0;
      if (r_state != S_BUSY) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + MAC_WDOG_W'(1);
        if (!r_mul_abort && !mul_done && (r_wdog == MAC_WDOG_W'(TIMEOUT - 2)))
          r_mul_abort <= 1'b1;
      end
    end
  end

  assign w_abort   = (r_state == S_BUSY) && r_mul_abort;
  assign mul_abort = r_mul_abort;
`else
  assign w_abort   = 1'b0;
  assign mul_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_BUSY;
      S_BUSY:   if (w_abort || mul_done) w_state_nxt = S_RESP;
      S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, engine start pulse, response register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_flag       <= 1'b0;
      r_mul_start  <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_mul_start <= w_accept;
      if (w_accept) begin
        r_mul_a <= req_a[32'(w_gid) * W +: W];
        r_mul_b <= req_b[32'(w_gid) * W +: W];
        r_id    <= w_gid;
        r_flag  <= req_acc[w_gid];
      end
      if (w_abort) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_acc_cur;
        r_resp_err   <= 1'b1;
      end else if (w_done) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_acc_new;
        r_resp_err   <= 1'b0;
      end else if (w_hs) begin
        r_resp_valid <= 1'b0;
        r_rr_ptr     <= w_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) r_acc[i] <= '0;
    end else if (w_done) begin
      r_acc[r_id] <= w_acc_new;
    end
  end

  assign mul_start  = r_mul_start;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mac_req_sched.sv
// Bench for mac_req_sched: directed and random ops checked against an arithmetic accumulator model.
// Build with +define+MAC_SCHED_TIMEOUT_EN to add the watchdog case (TIMEOUT=20).
module tb_mac_req_sched;

  localparam int unsigned W    = 256;
  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 2 * W;
`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 1000000;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_acc;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done;
  logic [PW-1:0]     mul_p;
  logic              mul_abort;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [PW-1:0]     resp_data;
  logic              resp_err;

  logic [W-1:0]  op_a [NREQ];
  logic [W-1:0]  op_b [NREQ];
  logic [PW-1:0] acc_m [NREQ];
  int            ptr_m;
  int            eng_lat;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_start = 0;
  logic [PW-1:0] got;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  mac_req_sched #(
    .W    (W),
`ifdef MAC_SCHED_TIMEOUT_EN
    .TIMEOUT(20),
`endif
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_acc    (req_acc),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_p      (mul_p),
    .mul_abort  (mul_abort),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always @(posedge clk) if (mul_start === 1'b1) n_start++;

  // Engine model: product appears eng_lat cycles after the start pulse; abandoned on reset.
  initial begin
    logic [PW-1:0] e_p;
    int            e_lat;
    bit            e_ok;
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mul_start === 1'b1) begin
        e_p   = PW'(mul_a) * PW'(mul_b);
        e_lat = eng_lat;
        e_ok  = 1'b1;
        for (int k = 0; k < e_lat && e_ok; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) e_ok = 1'b0;
        end
        if (e_ok) begin
          mul_p    = e_p;
          mul_done = 1'b1;
          @(negedge clk);
          mul_done = 1'b0;
          mul_p    = {16{$urandom}};
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: observed no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < int'(NREQ); k++)
      if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd_op(input bit full);
    logic [W-1:0] r;
    r = W'($urandom_range(0, 1000));
    if (full) for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One complete operation, entered and left just after a falling edge with the DUT idle.
  task automatic serve(input logic [NREQ-1:0] vld, input bit keep, input int lat,
                       input int delay, output logic [PW-1:0] data);
    int            g;
    int            cyc;
    int            st0;
    int            abort_cyc;
    bit            tmo;
    bit            stable;
    logic [PW-1:0] prod;
    logic [PW-1:0] want;
    g    = exp_grant(vld);
    tmo  = (lat >= TMO);
    prod = PW'(op_a[g]) * PW'(op_b[g]);
    want = tmo ? acc_m[g] : ((req_acc[g] ? acc_m[g] : '0) + prod);
    eng_lat   = lat;
    req_valid = vld;
    #1;
    cyc = 0;
    while (req_ready === '0 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("grant", PW'(req_ready), PW'(NREQ'(1) << g));
    st0       = n_start;
    cyc       = 0;
    abort_cyc = 0;
    do begin
      @(negedge clk); #1; cyc++;
      if (cyc == 1) begin
        chk("launch_start", PW'(mul_start), PW'(1));
        chk("launch_a", PW'(mul_a), PW'(op_a[g]));
        chk("launch_b", PW'(mul_b), PW'(op_b[g]));
        chk("launch_ready", PW'(req_ready), '0);
        if (!keep) req_valid[g] = 1'b0;
      end
      if (mul_abort === 1'b1) abort_cyc = cyc;
    end while (resp_valid !== 1'b1 && cyc < 200);
    chk("latency", PW'(cyc), PW'(tmo ? 2 + TMO : 2 + lat));
    chk("resp_id", PW'(resp_id), PW'(g));
    chk("resp_data", resp_data, want);
    chk("resp_err", PW'(resp_err), PW'(tmo));
    chk("start_count", PW'(n_start - st0), PW'(1));
    chk("abort_cycle", PW'(abort_cyc), PW'(tmo ? TMO + 1 : 0));
    data = resp_data;
    if (delay > 0) begin
      stable = 1'b1;
      for (int k = 0; k < delay; k++) begin
        @(negedge clk); #1;
        if (resp_valid !== 1'b1 || resp_data !== want || resp_id !== 2'(g) || req_ready !== '0)
          stable = 1'b0;
      end
      chk("resp_hold", PW'(stable), PW'(1));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    acc_m[g]   = want;
    ptr_m      = (g + 1) % NREQ;
    #1;
    chk("resp_drop", PW'(resp_valid), '0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_acc    = '0;
    resp_ready = 1'b0;
    eng_lat    = 1;
    ptr_m      = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      op_a[i]  = '0;
      op_b[i]  = '0;
      acc_m[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", PW'({req_ready, mul_start, mul_abort, resp_valid, resp_err, resp_id}), '0);
    chk("reset_mul_a", PW'(mul_a), '0);
    chk("reset_mul_b", PW'(mul_b), '0);
    chk("reset_resp_data", resp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single op and clear-then-add / accumulate on requester 1.
    op_a[0] = W'(3); op_b[0] = W'(5); req_acc = 4'b0000;
    serve(4'b0001, 1'b0, 3, 0, got);
    chk("single_15", got, PW'(15));
    op_a[1] = W'(2); op_b[1] = W'(7); req_acc = 4'b0000;
    serve(4'b0010, 1'b0, 2, 0, got);
    chk("acc_first_14", got, PW'(14));
    op_a[1] = W'(4); op_b[1] = W'(4); req_acc = 4'b0010;
    serve(4'b0010, 1'b0, 1, 0, got);
    chk("acc_second_30", got, PW'(30));

    // Full-width operands accumulated twice wrap mod 2^(2W).
    op_a[2] = '1; op_b[2] = '1; req_acc = 4'b0100;
    serve(4'b0100, 1'b0, 4, 0, got);
    serve(4'b0100, 1'b0, 2, 0, got);

    // Response backpressure with competing requesters still valid.
    for (int i = 0; i < int'(NREQ); i++) begin
      op_a[i] = rnd_op(1'b1); op_b[i] = rnd_op(1'b0);
    end
    req_acc = 4'b1010;
    serve(4'b1111, 1'b0, 2, 10, got);
    req_valid = '0;

    // Reset while the engine is busy.
    op_a[3] = W'(9); op_b[3] = W'(11); req_acc = 4'b0000; eng_lat = 4;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_ctrl", PW'({req_ready, mul_start, mul_abort, resp_valid, resp_err, resp_id}), '0);
    chk("midop_reset_mul_a", PW'(mul_a), '0);
    chk("midop_reset_resp_data", resp_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) acc_m[i] = '0;
    ptr_m = 0;
    @(negedge clk);

    // Fairness: everyone valid the whole time, accumulate flag set everywhere.
    req_acc = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        op_a[i] = rnd_op(1'b0); op_b[i] = rnd_op(1'b0);
      end
      serve(4'b1111, 1'b1, int'($urandom_range(1, 4)), 0, got);
    end
    req_valid = '0;

    // Random traffic.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        op_a[i] = rnd_op(1'($urandom_range(0, 1)));
        op_b[i] = rnd_op(1'($urandom_range(0, 1)));
      end
      req_acc = 4'($urandom_range(0, 15));
      serve(4'($urandom_range(1, 15)), 1'b0, int'($urandom_range(1, 4)),
            int'($urandom_range(0, 3)), got);
    end

`ifdef MAC_SCHED_TIMEOUT_EN
    // Engine answers only in the abort cycle: abort wins, accumulator untouched.
    op_a[ptr_m] = rnd_op(1'b1); op_b[ptr_m] = rnd_op(1'b1);
    req_acc = 4'b0000;
    serve(4'(1 << ptr_m), 1'b0, TMO, 0, got);
    req_acc = 4'b1111;
    serve(4'b1111, 1'b0, 3, 0, got);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
